cntr_seq_ctrl: RTL and testbench

//  Sequencer for an N-bit loadable up/down counter: loads a start value, steps toward an end value,

---
 rtl/cntr_ctrl_pkg.sv | 5 +
 rtl/updown_cntr.sv | 15 +
 rtl/cntr_seq_ctrl.sv | 60 ++++++
 tb/tb_cntr_seq_ctrl.sv | 65 ++++++
 4 files changed

// File: rtl/cntr_ctrl_pkg.sv
// cntr_ctrl_pkg: shared state encoding and default width for the counter sequencer
package cntr_ctrl_pkg;
  localparam int N_DEF = 4;
  typedef enum logic [2:0] {IDLE, LOAD, RUN, HOLD, DONE} state_t;
endpackage

// File: rtl/updown_cntr.sv
// updown_cntr: loadable up/down counter, load beats step, steps on every non-load cycle
module updown_cntr import cntr_ctrl_pkg::*; #(
  parameter int N = N_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ld,
  input  logic         up,
  input  logic [N-1:0] din,
  output logic [N-1:0] count
);
  always_ff @(posedge clk)
    if (!reset) count <= '0;
    else count <= ld ? din : up ? count + N'(1) : count - N'(1);
endmodule

// File: rtl/cntr_seq_ctrl.sv
// cntr_seq_ctrl: sequences the counter from a captured start value to a captured end value
module cntr_seq_ctrl import cntr_ctrl_pkg::*; #(
  parameter int N = N_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         abort,
  input  logic         pause,
  input  logic         rpt_en,
  input  logic         dir,
  input  logic [N-1:0] start_val,
  input  logic [N-1:0] end_val,
  output logic [N-1:0] count,
  output logic         busy,
  output logic         done
);
  state_t state, state_nx;
  logic dir_r, ld, up, match;
  logic [N-1:0] sv_r, ev_r, din;
  assign match = count == ev_r;
  always_ff @(posedge clk)
    if (!reset) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = state == IDLE ? (start ? LOAD : IDLE) :
               abort         ? IDLE :
               state == LOAD ? RUN :
               state == RUN  ? (match ? (rpt_en ? LOAD : DONE) : pause ? HOLD : RUN) :
               state == HOLD ? (pause ? HOLD : RUN) : IDLE;
  // The counter has no enable, so every non-stepping cycle reloads its own value
  always_comb begin
    ld   = !(state == RUN && !abort && !match && !pause);
    up   = dir_r;
    din  = (state == LOAD && !abort) ? sv_r : count;
    busy = state == LOAD || state == RUN || state == HOLD;
  end
  always_ff @(posedge clk)
    if (!reset) begin
      done  <= 1'b0;
      dir_r <= 1'b0;
      sv_r  <= '0;
      ev_r  <= '0;
    end else begin
      done <= state == RUN && match && !abort;
      if (state == IDLE && start) begin
        dir_r <= dir;
        sv_r  <= start_val;
        ev_r  <= end_val;
      end
    end
  updown_cntr #(.N(N)) u_cntr (
    .clk   (clk),
    .reset (reset),
    .ld    (ld),
    .up    (up),
    .din   (din),
    .count (count)
  );
endmodule

// File: tb/tb_cntr_seq_ctrl.sv
// tb_cntr_seq_ctrl: directed vectors with a per-cycle expected-output scoreboard
module tb_cntr_seq_ctrl;
  logic clk = 0, reset = 0, start = 0, abort = 0, pause = 0, rpt_en = 0, dir = 0;
  logic [3:0] start_val = 0, end_val = 0, count;
  logic busy, done;
  int n_chk = 0, n_fail = 0, tid = 0;
  typedef struct {logic [3:0] c; logic b; logic d; int id;} exp_t;
  exp_t q[$];
  always #5 clk = ~clk;
  cntr_seq_ctrl #(.N(4)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .pause(pause), .rpt_en(rpt_en),
    .dir(dir), .start_val(start_val), .end_val(end_val), .count(count), .busy(busy), .done(done)
  );
  always @(negedge clk)
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_chk++;
      if (count !== e.c || busy !== e.b || done !== e.d) begin
        n_fail++;
        $display("FAIL test%0d @%0t: count=%0d busy=%0b done=%0b, expected count=%0d busy=%0b done=%0b",
                 e.id, $time, count, busy, done, e.c, e.b, e.d);
      end
    end
  task automatic ex(input logic [3:0] c, input logic b, input logic d);
    @(posedge clk);
    #1;
    q.push_back('{c, b, d, tid});
  endtask
  task automatic go(input logic [3:0] s, input logic [3:0] e, input logic d);
    start = 1; start_val = s; end_val = e; dir = d;
  endtask
  initial begin
    ex(0, 0, 0); ex(0, 0, 0); reset = 1; ex(0, 0, 0);
    tid = 1; go(3, 7, 1); ex(0, 1, 0); start = 0;
    ex(3, 1, 0); ex(4, 1, 0); ex(5, 1, 0); ex(6, 1, 0); ex(7, 1, 0); ex(7, 0, 1); ex(7, 0, 0);
    tid = 2; go(2, 14, 0); ex(7, 1, 0); start = 0;
    ex(2, 1, 0); ex(1, 1, 0); ex(0, 1, 0); ex(15, 1, 0); ex(14, 1, 0); ex(14, 0, 1); ex(14, 0, 0); ex(14, 0, 0);
    tid = 3; go(5, 5, 1); ex(14, 1, 0); start = 0;
    ex(5, 1, 0); ex(5, 0, 1); ex(5, 0, 0);
    tid = 4; go(3, 7, 1); ex(5, 1, 0); start = 0;
    ex(3, 1, 0); ex(4, 1, 0); pause = 1;
    ex(4, 1, 0); ex(4, 1, 0); ex(4, 1, 0); pause = 0;
    ex(4, 1, 0); ex(5, 1, 0); ex(6, 1, 0); ex(7, 1, 0); ex(7, 0, 1); ex(7, 0, 0);
    tid = 5; go(0, 2, 1); rpt_en = 1; ex(7, 1, 0); start = 0;
    ex(0, 1, 0); ex(1, 1, 0); ex(2, 1, 0); ex(2, 1, 1); ex(0, 1, 0);
    start = 1; start_val = 9; end_val = 9; dir = 0; ex(1, 1, 0); start = 0;
    ex(2, 1, 0); ex(2, 1, 1); ex(0, 1, 0); rpt_en = 0;
    ex(1, 1, 0); ex(2, 1, 0); ex(2, 0, 1); ex(2, 0, 0);
    tid = 6; go(3, 9, 1); ex(2, 1, 0); start = 0;
    ex(3, 1, 0); ex(4, 1, 0); ex(5, 1, 0); reset = 0; ex(0, 0, 0); reset = 1; ex(0, 0, 0);
    tid = 7; go(3, 9, 1); ex(0, 1, 0); start = 0;
    ex(3, 1, 0); ex(4, 1, 0); ex(5, 1, 0); abort = 1; ex(5, 0, 0); abort = 0; ex(5, 0, 0);
    tid = 8; go(8, 8, 0); abort = 1; ex(5, 1, 0); start = 0; abort = 0;
    ex(8, 1, 0); ex(8, 0, 1); ex(8, 0, 0);
    repeat (2) @(posedge clk);
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
